// File: rtl/mips_mc_datapath_if.sv
// mips_mc_datapath_if: instruction and data memory bus of the multi-cycle MIPS datapath.
interface mips_mc_datapath_if #(parameter int PC_W = 10);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ack;
   logic            dmem_req;
   logic            dmem_we;
   logic [31:0]     dmem_addr;
   logic [31:0]     dmem_wdata;
   logic [31:0]     dmem_rdata;
   logic            dmem_ack;
   modport master (output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
                   input imem_rdata, imem_ack, dmem_rdata, dmem_ack);
   modport slave (input imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output imem_rdata, imem_ack, dmem_rdata, dmem_ack);
endinterface

// File: rtl/mips_mc_datapath.sv
// mips_mc_datapath: multi-cycle MIPS subset (FETCH/DECODE/EXEC/MEM/WB) with external memory handshakes.
// Define MC_BNE_EN to add bne (opcode 05); otherwise opcode 05 is illegal.
module mips_mc_datapath #(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   mips_mc_datapath_if.master bus,
   output logic               retire,
   output logic [31:0]        result,
   output logic               illegal
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
   state_t state, state_nx;
   logic [PC_W-1:0] pc;
   logic [31:0] ir, a, b, imm, alu_out, mdr, alu;
   logic [31:0] rf [32];
   logic [5:0] op, fn;
   logic [4:0] dst;
   logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, legal, take;
   assign op = ir[31:26];
   assign fn = ir[5:0];
   assign is_r = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
   assign is_addi = op == 6'h08;
   assign is_lw = op == 6'h23;
   assign is_sw = op == 6'h2B;
   assign is_beq = op == 6'h04;
   assign is_j = op == 6'h02;
`ifdef MC_BNE_EN
   assign is_bne = op == 6'h05;
`else
   assign is_bne = 1'b0;
`endif
   assign legal = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;
   assign take = (is_beq && a == b) || (is_bne && a != b);
   assign dst = is_r ? ir[15:11] : ir[20:16];
   assign alu = !is_r ? a + imm :
                fn == 6'h20 ? a + b :
                fn == 6'h22 ? a - b :
                fn == 6'h24 ? a & b :
                fn == 6'h25 ? a | b : {31'b0, $signed(a) < $signed(b)};
   // imem_req is gated by reset so it rises in the very first cycle after release
   assign bus.imem_req = state == FETCH && !reset;
   assign bus.imem_addr = pc;
   assign bus.dmem_req = state == MEM;
   assign bus.dmem_we = state == MEM && is_sw;
   assign bus.dmem_addr = alu_out;
   assign bus.dmem_wdata = b;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= FETCH;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      retire = 1'b0;
      case (state)
         FETCH: state_nx = bus.imem_ack ? DECODE : FETCH;
         DECODE: state_nx = EXEC;
         EXEC: begin
            state_nx = (is_r | is_addi) ? WB : (is_lw | is_sw) ? MEM : FETCH;
            retire = !(is_r | is_addi | is_lw | is_sw);
         end
         MEM: begin
            state_nx = !bus.dmem_ack ? MEM : is_lw ? WB : FETCH;
            retire = bus.dmem_ack && is_sw;
         end
         WB: begin
            state_nx = FETCH;
            retire = 1'b1;
         end
         default: state_nx = FETCH;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= RESET_PC;
         ir <= '0;
         a <= '0;
         b <= '0;
         imm <= '0;
         alu_out <= '0;
         mdr <= '0;
         result <= '0;
         illegal <= 1'b0;
         rf <= '{default: '0};
      end else begin
         if (state == FETCH && bus.imem_ack) begin
            ir <= bus.imem_rdata;
            pc <= pc + PC_W'(4);
         end
         if (state == DECODE) begin
            a <= rf[ir[25:21]];
            b <= rf[ir[20:16]];
            imm <= {{16{ir[15]}}, ir[15:0]};
         end
         // pc already holds PC+4 here, so branch offsets and illegal NOPs build on it
         if (state == EXEC) begin
            alu_out <= alu;
            if (take) pc <= pc + PC_W'(imm << 2);
            if (is_j) pc <= PC_W'({ir[25:0], 2'b00});
            if (!legal) illegal <= 1'b1;
         end
         if (state == MEM && bus.dmem_ack) mdr <= bus.dmem_rdata;
         if (state == WB) begin
            result <= is_lw ? mdr : alu_out;
            if (dst != 5'd0) rf[dst] <= is_lw ? mdr : alu_out;
         end
      end
endmodule

// File: tb/tb_mips_mc_datapath.sv
// tb_mips_mc_datapath: directed instruction table plus reset corner sequences for mips_mc_datapath.
module tb_mips_mc_datapath;
   localparam int PC_W = 10;
   typedef struct {
      logic [31:0] instr;
      int          dly;
      int          cyc;
      logic [31:0] res;
      bit          chk_res;
      logic [9:0]  pc;
      bit          ill;
      int          mem;
      logic [31:0] daddr;
      logic [31:0] wdata;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic retire, illegal;
   logic [31:0] result;
   int errors = 0;
   int checks = 0;
   logic [31:0] dmem [16];
   vec_t tbl [21];
   bit bne_ill;
   logic [9:0] bne_pc;
   mips_mc_datapath_if #(.PC_W(PC_W)) bus ();
   mips_mc_datapath #(.PC_W(PC_W), .RESET_PC(10'h000)) dut (
      .clk(clk), .reset(reset), .bus(bus), .retire(retire), .result(result), .illegal(illegal));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Serves one instruction from the current negedge until retire, then checks the outcome.
   task automatic run(input vec_t v, input int idx);
      int cyc = 0;
      int reqc = 0;
      int dwait = 0;
      bit done = 0;
      bit both = 0;
      logic [31:0] da = '0;
      logic [31:0] dw = '0;
      logic dwe = 1'b0;
      while (!done && cyc < 60) begin
         bus.imem_ack = 1'b1;
         bus.imem_rdata = v.instr;
         bus.dmem_ack = bus.dmem_req ? (dwait >= v.dly) : 1'b1;
         bus.dmem_rdata = dmem[bus.dmem_addr[5:2]];
         #1;
         cyc++;
         if (bus.imem_req && bus.dmem_req) both = 1;
         if (bus.dmem_req) begin
            reqc++;
            dwait++;
            da = bus.dmem_addr;
            dw = bus.dmem_wdata;
            dwe = bus.dmem_we;
            if (bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr[5:2]] = bus.dmem_wdata;
         end
         done = retire;
         @(negedge clk);
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      #1;
      chk($sformatf("v%0d retired", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.cyc));
      chk($sformatf("v%0d next_pc", idx), 32'(bus.imem_addr), 32'(v.pc));
      chk($sformatf("v%0d illegal", idx), 32'(illegal), 32'(v.ill));
      chk($sformatf("v%0d req_overlap", idx), 32'(both), 32'd0);
      if (v.chk_res) chk($sformatf("v%0d result", idx), result, v.res);
      if (v.mem != 0) begin
         chk($sformatf("v%0d dmem_addr", idx), da, v.daddr);
         chk($sformatf("v%0d dmem_req_cycles", idx), 32'(reqc), 32'(v.dly + 1));
         chk($sformatf("v%0d dmem_we", idx), 32'(dwe), 32'(v.mem == 2));
      end
      if (v.mem == 2) chk($sformatf("v%0d dmem_wdata", idx), dw, v.wdata);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
`ifdef MC_BNE_EN
      bne_ill = 1'b0;
      bne_pc = 10'h048;
`else
      bne_ill = 1'b1;
      bne_pc = 10'h044;
`endif
      foreach (dmem[i]) dmem[i] = 32'hDEADBEEF;
      tbl[0]  = '{32'h20010005, 0, 4, 32'h00000005, 1'b1, 10'h004, 1'b0, 0, 32'h0, 32'h0};
      tbl[1]  = '{32'h20020007, 0, 4, 32'h00000007, 1'b1, 10'h008, 1'b0, 0, 32'h0, 32'h0};
      tbl[2]  = '{32'h00221822, 0, 4, 32'hFFFFFFFE, 1'b1, 10'h00C, 1'b0, 0, 32'h0, 32'h0};
      tbl[3]  = '{32'h0022202A, 0, 4, 32'h00000001, 1'b1, 10'h010, 1'b0, 0, 32'h0, 32'h0};
      tbl[4]  = '{32'h00223824, 0, 4, 32'h00000005, 1'b1, 10'h014, 1'b0, 0, 32'h0, 32'h0};
      tbl[5]  = '{32'h00224025, 0, 4, 32'h00000007, 1'b1, 10'h018, 1'b0, 0, 32'h0, 32'h0};
      tbl[6]  = '{32'h00624820, 0, 4, 32'h00000005, 1'b1, 10'h01C, 1'b0, 0, 32'h0, 32'h0};
      tbl[7]  = '{32'h0061502A, 0, 4, 32'h00000001, 1'b1, 10'h020, 1'b0, 0, 32'h0, 32'h0};
      tbl[8]  = '{32'hAC010008, 3, 7, 32'h00000001, 1'b1, 10'h024, 1'b0, 2, 32'h8, 32'h5};
      tbl[9]  = '{32'h8C050008, 3, 8, 32'h00000005, 1'b1, 10'h028, 1'b0, 1, 32'h8, 32'h0};
      tbl[10] = '{32'h20000009, 0, 4, 32'h00000000, 1'b0, 10'h02C, 1'b0, 0, 32'h0, 32'h0};
      tbl[11] = '{32'h00006020, 0, 4, 32'h00000000, 1'b1, 10'h030, 1'b0, 0, 32'h0, 32'h0};
      tbl[12] = '{32'h10250002, 0, 3, 32'h00000000, 1'b1, 10'h03C, 1'b0, 0, 32'h0, 32'h0};
      tbl[13] = '{32'h10220002, 0, 3, 32'h00000000, 1'b1, 10'h040, 1'b0, 0, 32'h0, 32'h0};
      tbl[14] = '{32'h14220001, 0, 3, 32'h00000000, 1'b1, bne_pc, bne_ill, 0, 32'h0, 32'h0};
      tbl[15] = '{32'h08000040, 0, 3, 32'h00000000, 1'b1, 10'h100, bne_ill, 0, 32'h0, 32'h0};
      tbl[16] = '{32'hFC010000, 0, 3, 32'h00000000, 1'b1, 10'h104, 1'b1, 0, 32'h0, 32'h0};
      tbl[17] = '{32'h00206820, 0, 4, 32'h00000005, 1'b1, 10'h108, 1'b1, 0, 32'h0, 32'h0};
      tbl[18] = '{32'h080000FF, 0, 3, 32'h00000005, 1'b1, 10'h3FC, 1'b1, 0, 32'h0, 32'h0};
      tbl[19] = '{32'h10000001, 0, 3, 32'h00000005, 1'b1, 10'h004, 1'b1, 0, 32'h0, 32'h0};
      tbl[20] = '{32'h200EFFFF, 0, 4, 32'hFFFFFFFF, 1'b1, 10'h008, 1'b1, 0, 32'h0, 32'h0};
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst dmem_req", 32'(bus.dmem_req), 32'd0);
      chk("rst retire", 32'(retire), 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("first imem_req", 32'(bus.imem_req), 32'd1);
      chk("first imem_addr", 32'(bus.imem_addr), 32'd0);
      for (int i = 0; i < 21; i++) run(tbl[i], i);
      // Reset in the middle of a stalled store must drop the data request without a clock edge.
      bus.imem_rdata = 32'hAC010008;
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b0;
      for (int k = 0; k < 10 && !bus.dmem_req; k++) @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      chk("mid dmem_req before reset", 32'(bus.dmem_req), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid dmem_req", 32'(bus.dmem_req), 32'd0);
      chk("mid dmem_we", 32'(bus.dmem_we), 32'd0);
      chk("mid imem_req", 32'(bus.imem_req), 32'd0);
      chk("mid retire", 32'(retire), 32'd0);
      chk("mid result", result, 32'd0);
      chk("mid illegal", 32'(illegal), 32'd0);
      chk("mid pc", 32'(bus.imem_addr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post imem_req", 32'(bus.imem_req), 32'd1);
      chk("post imem_addr", 32'(bus.imem_addr), 32'd0);
      run('{32'h202F0003, 0, 4, 32'h00000003, 1'b1, 10'h004, 1'b0, 0, 32'h0, 32'h0}, 100);
      run('{32'h20010005, 0, 4, 32'h00000005, 1'b1, 10'h008, 1'b0, 0, 32'h0, 32'h0}, 101);
      run('{32'h00011080, 0, 3, 32'h00000005, 1'b1, 10'h00C, 1'b1, 0, 32'h0, 32'h0}, 102);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
